// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI frame slave.
//   state_t   : FSM states of the frame tracker
//   CPOL/CPHA : named mode values for the top-level parameters
//   edge_sel  : picks the synchronised SPI_CLK rise or fall pulse for a
//               leading/trailing edge under a given idle polarity
package spi_pkg;

   typedef enum logic [1:0] {
      WAIT_CS = 2'd0,
      IDLE    = 2'd1,
      SHIFT   = 2'd2,
      OVER    = 2'd3
   } state_t;

   localparam logic CPOL_IDLE_LOW     = 1'b0;
   localparam logic CPHA_SAMPLE_LEAD  = 1'b0;
   localparam logic CPHA_SAMPLE_TRAIL = 1'b1;

   // Leading edge leaves the idle level: a rise when idle is low, a fall when idle is high.
   function automatic logic edge_sel(input logic i_lead, input logic i_cpol,
                                     input logic i_rise, input logic i_fall);
      return (i_lead ^ i_cpol) ? i_rise : i_fall;
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchroniser for one asynchronous SPI pin,
// followed by a level flop with registered rise/fall pulses.
// A pin change shows on o_level/o_rise/o_fall SYNC_STAGES+1 cycles later.
//   sys_clock, reset : system clock, synchronous active-high reset
//   i_pin            : asynchronous pin
//   o_level          : synchronised level
//   o_rise/o_fall    : one-cycle pulses aligned with the o_level change
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic sys_clock,
   input  logic reset,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_level, r_rise, r_fall;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         r_sync  <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_level <= w_synced;
         r_rise  <= w_synced & ~r_level;
         r_fall  <= ~w_synced & r_level;
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: oversampled SPI peripheral that receives an MSB-first
// FRAME_W-bit frame on SPI_PICO and returns a held result word on SPI_POCI.
//   sys_clock, reset      : system clock, synchronous active-high reset
//   SPI_CLK/CS/PICO       : asynchronous SPI pins (CS active low)
//   SPI_POCI              : reply bit, 0 whenever no frame is in progress
//   tx_data, tx_wr        : result word and its write strobe (holding register)
//   rx_data               : last exact-length frame
//   rx_valid/short/long   : one-cycle end-of-frame status pulses
//   tx_underrun           : frame began without a tx_wr since the previous frame start
//   busy                  : frame in progress (SHIFT or OVER)
module spi_frame_slave
   import spi_pkg::*;
#(
   parameter int   FRAME_W     = 64,
   parameter logic CPOL        = CPOL_IDLE_LOW,
   parameter logic CPHA        = CPHA_SAMPLE_LEAD,
   parameter int   SYNC_STAGES = 2
) (
   input  logic               sys_clock,
   input  logic               reset,
   input  logic               SPI_CLK,
   input  logic               SPI_CS,
   input  logic               SPI_PICO,
   output logic               SPI_POCI,
   input  logic [FRAME_W-1:0] tx_data,
   input  logic               tx_wr,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   output logic               rx_short,
   output logic               rx_long,
   output logic               tx_underrun,
   output logic               busy
);

   localparam int CNT_W = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

   logic w_clk_rise, w_clk_fall, w_clk_level_unused;
   logic w_cs_level, w_cs_rise, w_cs_fall;
   logic w_pico, w_pico_rise_unused, w_pico_fall_unused;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .sys_clock(sys_clock), .reset(reset), .i_pin(SPI_CLK),
      .o_level(w_clk_level_unused), .o_rise(w_clk_rise), .o_fall(w_clk_fall));
   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .sys_clock(sys_clock), .reset(reset), .i_pin(SPI_CS),
      .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pico (
      .sys_clock(sys_clock), .reset(reset), .i_pin(SPI_PICO),
      .o_level(w_pico), .o_rise(w_pico_rise_unused), .o_fall(w_pico_fall_unused));

   state_t             r_state, w_next;
   logic [FRAME_W-1:0] r_rx_shift, r_tx_shift, r_hold, r_rx_data;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic               r_long, r_wr_seen, r_first;
   logic               r_rx_valid, r_rx_short, r_rx_long, r_underrun;
   logic               w_sample, w_shift, w_busy, w_start, w_end;

   assign w_sample = edge_sel(CPHA == CPHA_SAMPLE_LEAD,  CPOL, w_clk_rise, w_clk_fall);
   assign w_shift  = edge_sel(CPHA == CPHA_SAMPLE_TRAIL, CPOL, w_clk_rise, w_clk_fall);
   assign w_busy   = (r_state == SHIFT) || (r_state == OVER);
   assign w_start  = (r_state == IDLE) && w_cs_fall;
   // CS rise takes priority over any clock edge seen in the same cycle.
   assign w_end    = w_busy && w_cs_rise;

   always_ff @(posedge sys_clock) begin
      if (reset) r_state <= WAIT_CS;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         WAIT_CS: if (w_cs_level) w_next = IDLE;
         IDLE:    if (w_cs_fall)  w_next = SHIFT;
         SHIFT: begin
            if (w_cs_rise)                             w_next = IDLE;
            else if (w_sample && r_bit_cnt == CNT_LAST) w_next = OVER;
         end
         OVER:    if (w_cs_rise)  w_next = IDLE;
         default: w_next = WAIT_CS;
      endcase
   end

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         r_rx_shift <= '0;
         r_tx_shift <= '0;
         r_hold     <= '0;
         r_rx_data  <= '0;
         r_bit_cnt  <= '0;
         r_long     <= 1'b0;
         r_wr_seen  <= 1'b0;
         r_first    <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_short <= 1'b0;
         r_rx_long  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_rx_short <= 1'b0;
         r_rx_long  <= 1'b0;
         r_underrun <= 1'b0;
         if (tx_wr) begin
            r_hold    <= tx_data;
            r_wr_seen <= 1'b1;
         end
         if (w_start) begin
            // A write landing on the CS-fall cycle is sent in this frame.
            r_tx_shift <= tx_wr ? tx_data : r_hold;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_long     <= 1'b0;
            // With CPHA=1 the first leading edge only exposes the MSB.
            r_first    <= (CPHA == CPHA_SAMPLE_TRAIL);
            r_underrun <= ~r_wr_seen;
            r_wr_seen  <= 1'b0;
         end else if (w_end) begin
            if (r_long) begin
               r_rx_long <= 1'b1;
            end else if (r_bit_cnt == CNT_FULL) begin
               r_rx_valid <= 1'b1;
               r_rx_data  <= r_rx_shift;
            end else if (r_bit_cnt != '0) begin
               r_rx_short <= 1'b1;
            end
         end else if (w_busy) begin
            if (w_sample) begin
               if (r_state == SHIFT) begin
                  r_rx_shift <= {r_rx_shift[FRAME_W-2:0], w_pico};
                  r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
               end else begin
                  r_long <= 1'b1;
               end
            end
            if (w_shift) begin
               if (r_first) r_first    <= 1'b0;
               else         r_tx_shift <= {r_tx_shift[FRAME_W-2:0], 1'b0};
            end
         end
      end
   end

   assign SPI_POCI    = w_busy & ~r_first & r_tx_shift[FRAME_W-1];
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign rx_short    = r_rx_short;
   assign rx_long     = r_rx_long;
   assign tx_underrun = r_underrun;
   assign busy        = w_busy;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: instance A (64-bit, mode 0) and instance B
// (32-bit, CPOL=1 CPHA=1). A frame-level model predicts status pulses and
// reply bits; pulses are queued and checked by per-instance monitors.
module tb_spi_frame_slave;

   localparam int H = 8;   // SPI half period in sys_clock cycles

   typedef struct packed {
      logic [3:0]  flags;  // {valid, short, long, underrun}
      logic [63:0] data;   // rx_data expected while the pulse is high
   } ev_t;

   logic        sys_clock = 1'b0;
   logic        rst [2];
   logic        pc [2], ps [2], pp [2];
   logic        tx_wr [2];
   logic [63:0] a_tx_data, a_rx_data;
   logic [31:0] b_tx_data, b_rx_data;
   logic        a_poci, a_valid, a_short, a_long, a_under, a_busy;
   logic        b_poci, b_valid, b_short, b_long, b_under, b_busy;

   int          errors = 0;
   int          checks = 0;
   ev_t         qa[$], qb[$];
   logic [63:0] m_hold [2];
   logic        m_wr_seen [2];
   logic [63:0] m_last_rx [2];

   always #5 sys_clock = ~sys_clock;

   spi_frame_slave u_a (
      .sys_clock(sys_clock), .reset(rst[0]), .SPI_CLK(pc[0]), .SPI_CS(ps[0]),
      .SPI_PICO(pp[0]), .SPI_POCI(a_poci), .tx_data(a_tx_data), .tx_wr(tx_wr[0]),
      .rx_data(a_rx_data), .rx_valid(a_valid), .rx_short(a_short), .rx_long(a_long),
      .tx_underrun(a_under), .busy(a_busy));

   spi_frame_slave #(.FRAME_W(32), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_b (
      .sys_clock(sys_clock), .reset(rst[1]), .SPI_CLK(pc[1]), .SPI_CS(ps[1]),
      .SPI_PICO(pp[1]), .SPI_POCI(b_poci), .tx_data(b_tx_data), .tx_wr(tx_wr[1]),
      .rx_data(b_rx_data), .rx_valid(b_valid), .rx_short(b_short), .rx_long(b_long),
      .tx_underrun(b_under), .busy(b_busy));

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int fw(input int inst);
      return (inst == 0) ? 64 : 32;
   endfunction

   function automatic logic [63:0] mask(input int inst);
      return (inst == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic get_poci(input int inst);
      return (inst == 0) ? a_poci : b_poci;
   endfunction

   function automatic logic get_busy(input int inst);
      return (inst == 0) ? a_busy : b_busy;
   endfunction

   task automatic push(input int inst, input logic [3:0] f, input logic [63:0] d);
      ev_t e;
      e.flags = f;
      e.data  = d;
      if (inst == 0) qa.push_back(e);
      else           qb.push_back(e);
   endtask

   task automatic drive_tx(input int inst, input logic [63:0] d);
      if (inst == 0) a_tx_data = d;
      else           b_tx_data = d[31:0];
      tx_wr[inst] = 1'b1;
      @(negedge sys_clock);
      tx_wr[inst] = 1'b0;
   endtask

   task automatic write_tx(input int inst, input logic [63:0] d);
      drive_tx(inst, d);
      m_hold[inst]    = d & mask(inst);
      m_wr_seen[inst] = 1'b1;
   endtask

   // One CS window of n clocks sending pd[n-1:0] MSB first. reset_at >= 0
   // pulses reset before that bit; wr_fall writes wr_val on the CS-fall detect cycle.
   task automatic frame(input int inst, input int n, input logic [95:0] pd,
                        input int reset_at, input bit wr_fall, input logic [63:0] wr_val);
      int          w;
      logic        cpol, cpha;
      logic [63:0] exp_tx;
      logic [95:0] got, expm;
      bit          aborted;
      w = fw(inst);
      cpol = (inst == 1);
      cpha = (inst == 1);
      aborted = 0;
      got = '0;
      expm = '0;
      if (!m_wr_seen[inst]) push(inst, 4'b0001, m_last_rx[inst]);
      m_wr_seen[inst] = 1'b0;
      if (wr_fall) m_hold[inst] = wr_val & mask(inst);
      exp_tx = m_hold[inst];
      ps[inst] = 1'b0;
      if (wr_fall) begin
         // CS fall reaches the FSM three cycles after the pin change.
         repeat (3) @(negedge sys_clock);
         drive_tx(inst, wr_val);
         repeat (H - 4) @(negedge sys_clock);
      end else begin
         repeat (H) @(negedge sys_clock);
      end
      for (int i = 0; i < n; i++) begin
         if (i == reset_at) begin
            rst[inst] = 1'b1;
            repeat (3) @(negedge sys_clock);
            rst[inst] = 1'b0;
            m_hold[inst] = '0;
            m_wr_seen[inst] = 1'b0;
            m_last_rx[inst] = '0;
            aborted = 1;
            @(negedge sys_clock);
            chk("busy_after_reset", {95'b0, get_busy(inst)}, 96'b0);
         end
         if (i == w / 2 && !aborted)
            chk((inst == 0) ? "a_busy_mid" : "b_busy_mid", {95'b0, get_busy(inst)}, 96'd1);
         expm[i] = (i < w) ? exp_tx[w-1-i] : 1'b0;
         if (!cpha) begin
            pp[inst] = pd[n-1-i];
            repeat (2) @(negedge sys_clock);
            got[i] = get_poci(inst);
         end
         pc[inst] = ~cpol;
         if (cpha) pp[inst] = pd[n-1-i];
         repeat (H) @(negedge sys_clock);
         if (cpha) got[i] = get_poci(inst);
         pc[inst] = cpol;
         repeat (H) @(negedge sys_clock);
      end
      if (!aborted) begin
         if (n == w) begin
            m_last_rx[inst] = pd[63:0] & mask(inst);
            push(inst, 4'b1000, m_last_rx[inst]);
         end else if (n > w) begin
            push(inst, 4'b0010, m_last_rx[inst]);
         end else if (n > 0) begin
            push(inst, 4'b0100, m_last_rx[inst]);
         end
      end
      ps[inst] = 1'b1;
      repeat (2 * H) @(negedge sys_clock);
      if (!aborted && n > 0)
         chk((inst == 0) ? "a_miso" : "b_miso", got, expm);
   endtask

   always @(negedge sys_clock) begin
      logic [3:0] f;
      ev_t e;
      f = {a_valid, a_short, a_long, a_under};
      if (f != 4'b0000) begin
         if (qa.size() == 0) chk("a_unexpected_pulse", {92'b0, f}, 96'b0);
         else begin
            e = qa.pop_front();
            chk("a_pulse_kind", {92'b0, f}, {92'b0, e.flags});
            chk("a_rx_data", {32'b0, a_rx_data}, {32'b0, e.data});
         end
      end
   end

   always @(negedge sys_clock) begin
      logic [3:0] f;
      ev_t e;
      f = {b_valid, b_short, b_long, b_under};
      if (f != 4'b0000) begin
         if (qb.size() == 0) chk("b_unexpected_pulse", {92'b0, f}, 96'b0);
         else begin
            e = qb.pop_front();
            chk("b_pulse_kind", {92'b0, f}, {92'b0, e.flags});
            chk("b_rx_data", {64'b0, b_rx_data}, {32'b0, e.data});
         end
      end
   end

   initial begin
      pc[0] = 1'b0; pc[1] = 1'b1;
      ps[0] = 1'b1; ps[1] = 1'b1;
      pp[0] = 1'b0; pp[1] = 1'b0;
      tx_wr[0] = 1'b0; tx_wr[1] = 1'b0;
      rst[0] = 1'b1; rst[1] = 1'b1;
      a_tx_data = '0; b_tx_data = '0;
      for (int k = 0; k < 2; k++) begin
         m_hold[k] = '0; m_wr_seen[k] = 1'b0; m_last_rx[k] = '0;
      end
      repeat (5) @(negedge sys_clock);
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge sys_clock);
      chk("a_rst_rx_data", {32'b0, a_rx_data}, 96'b0);
      chk("a_rst_flags", {92'b0, a_valid, a_short, a_long, a_under}, 96'b0);
      chk("a_rst_busy_poci", {94'b0, a_busy, a_poci}, 96'b0);
      chk("b_rst_rx_data", {64'b0, b_rx_data}, 96'b0);
      chk("b_rst_flags", {92'b0, b_valid, b_short, b_long, b_under}, 96'b0);
      chk("b_rst_busy_poci", {94'b0, b_busy, b_poci}, 96'b0);
      repeat (10) @(negedge sys_clock);

      // Directed mode-0 frames
      write_tx(0, 64'h0000_0000_DEAD_BEEF);
      frame(0, 64, {32'h0, 32'h430F_8F5C, 32'hC2AE_BDFE}, -1, 0, 64'h0);
      frame(0, 64, {$urandom, $urandom, $urandom}, -1, 0, 64'h0);
      write_tx(0, {$urandom, $urandom});
      frame(0, 40, {$urandom, $urandom, $urandom}, -1, 0, 64'h0);
      write_tx(0, {$urandom, $urandom});
      frame(0, 64, {$urandom, $urandom, $urandom}, -1, 0, 64'h0);
      frame(0, 66, {$urandom, $urandom, $urandom}, -1, 0, 64'h0);

      // Holding register rewritten mid-frame goes out on the next frame
      write_tx(0, {$urandom, $urandom});
      fork
         frame(0, 64, {$urandom, $urandom, $urandom}, -1, 0, 64'h0);
         begin
            repeat (400) @(negedge sys_clock);
            write_tx(0, {$urandom, $urandom});
         end
      join
      frame(0, 64, {$urandom, $urandom, $urandom}, -1, 0, 64'h0);

      // Randomized frame lengths and writes
      for (int k = 0; k < 10; k++) begin
         int r, n;
         r = $urandom_range(0, 5);
         if (r <= 2)      n = 64;
         else if (r == 3) n = $urandom_range(1, 63);
         else if (r == 4) n = 64 + $urandom_range(1, 3);
         else             n = 0;
         if ($urandom_range(0, 1) == 1) write_tx(0, {$urandom, $urandom});
         frame(0, n, {$urandom, $urandom, $urandom}, -1, 0, 64'h0);
      end

      // Reset cutting into a frame, then a clean frame
      write_tx(0, {$urandom, $urandom});
      frame(0, 64, {$urandom, $urandom, $urandom}, 20, 0, 64'h0);
      repeat (20) @(negedge sys_clock);
      frame(0, 64, {$urandom, $urandom, $urandom}, -1, 0, 64'h0);

      // Write on the CS-fall detect cycle wins
      write_tx(0, {$urandom, $urandom});
      frame(0, 64, {$urandom, $urandom, $urandom}, -1, 1, 64'h1);

      // CPOL=1 CPHA=1, 32-bit
      write_tx(1, 64'h0000_0000_1234_5678);
      frame(1, 32, {64'h0, 32'hA5C3_0F96}, -1, 0, 64'h0);
      for (int k = 0; k < 4; k++) begin
         int n;
         n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 34) : 32;
         if ($urandom_range(0, 1) == 1) write_tx(1, {$urandom, $urandom});
         frame(1, n, {$urandom, $urandom, $urandom}, -1, 0, 64'h0);
      end

      repeat (20) @(negedge sys_clock);
      chk("a_pending_pulses", qa.size(), 96'b0);
      chk("b_pending_pulses", qb.size(), 96'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
